// File: rtl/err_scan_ctrl.sv
// err_scan_ctrl: buffers an 8-word frame, scans it against D0/D1 for
// deviating words and reports the agreed word plus the position of a single
// outlier, or flags the frame as unresolvable.
module err_scan_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         e,
    output logic         multi,
    output logic [2:0]   idx
);

    typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

    state_t       state, state_n;
    logic [W-1:0] mem [8];
    logic [2:0]   widx;     // next buffer slot to fill
    logic [2:0]   sidx;     // word compared this SCAN cycle (1..7)
    logic [3:0]   c0;       // words equal to D0 so far
    logic [2:0]   c1;       // words (i>=2) equal to D1 so far
    logic [2:0]   fm;       // first word differing from D0; 0 means none yet
    logic         accept;
    logic         hit0, hit1;
    logic [3:0]   c0_n;
    logic [2:0]   c1_n, fm_n;

    // a clear in the same cycle wins over the word handshake
    assign accept = in_valid && in_ready && !clr;

    // this cycle's comparison folded into the counters; the final SCAN
    // cycle resolves from these so the 7th comparison is not lost
    always_comb begin
        hit0 = (mem[sidx] == mem[0]);
        hit1 = (sidx >= 3'd2) && (mem[sidx] == mem[1]);
        c0_n = c0 + {3'b000, hit0};
        c1_n = c1 + {2'b00, hit1};
        fm_n = (fm == 3'd0 && !hit0) ? sidx : fm;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        if (clr) begin
            state_n = LOAD;
        end else begin
            case (state)
                LOAD:    if (accept && widx == 3'd7) state_n = SCAN;
                SCAN:    if (sidx == 3'd7)           state_n = DONE;
                DONE:    if (out_ready)              state_n = LOAD;
                default:                             state_n = LOAD;
            endcase
        end
    end

    // handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == DONE);
    end

    // frame buffer, scan counters and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            widx  <= 3'd0;
            sidx  <= 3'd1;
            c0    <= 4'd0;
            c1    <= 3'd0;
            fm    <= 3'd0;
            y     <= '0;
            e     <= 1'b0;
            multi <= 1'b0;
            idx   <= 3'd0;
        end else if (clr) begin
            widx  <= 3'd0;
            sidx  <= 3'd1;
            c0    <= 4'd0;
            c1    <= 3'd0;
            fm    <= 3'd0;
            y     <= '0;
            e     <= 1'b0;
            multi <= 1'b0;
            idx   <= 3'd0;
        end else begin
            case (state)
                LOAD: begin
                    sidx <= 3'd1;
                    c0   <= 4'd0;
                    c1   <= 3'd0;
                    fm   <= 3'd0;
                    if (accept) begin
                        mem[widx] <= in_data;
                        widx      <= widx + 3'd1;
                    end
                end
                SCAN: begin
                    c0   <= c0_n;
                    c1   <= c1_n;
                    fm   <= fm_n;
                    sidx <= sidx + 3'd1;
                    if (sidx == 3'd7) begin
                        if (c0_n == 4'd7) begin
                            y <= mem[0]; e <= 1'b0; multi <= 1'b0; idx <= 3'd0;
                        end else if (c0_n == 4'd6) begin
                            y <= mem[0]; e <= 1'b1; multi <= 1'b0; idx <= fm_n;
                        end else if (c0_n == 4'd0 && c1_n == 3'd6) begin
                            y <= mem[1]; e <= 1'b1; multi <= 1'b0; idx <= 3'd0;
                        end else begin
                            y <= '0;     e <= 1'b1; multi <= 1'b1; idx <= 3'd0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        widx  <= 3'd0;
                        y     <= '0;
                        e     <= 1'b0;
                        multi <= 1'b0;
                        idx   <= 3'd0;
                    end
                end
                default: widx <= 3'd0;
            endcase
        end
    end

endmodule
